uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped UART peripheral sitting directly on the single-cycle RISC-V core's data port, downstream of the core. It consumes the core's ALU address, store data and store/load strobes, and returns load data. It serialises bytes to a TX pin and deserialises an RX pin into a one-byte holding register. Software polls a status register; there is no interrupt.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit; 868 gives 115200 baud at 100 MHz; legal range ≥ 4.
- `BASE_ADDR`, default 32'h0000_1000: base of the 16-byte register window; must be 16-byte aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address from the core's ALU result.
- `wdata`  in  32  store data; only bits [7:0] and [3:2] are used.
- `memwrite`  in  1  store strobe.
- `resultsrc`  in  1  load strobe: the current instruction is a load.
- `rdata`  out  32  combinational load data.
- `tx`  out  1  serial output; idles high.
- `rx`  in  1  serial input; asynchronous to `clk`.

## Operation
- Hit condition: `addr[31:4] == BASE_ADDR[31:4]`; `addr[1:0]` ignored. Off-window: `rdata` = 0, writes ignored.
- Offset 0x0 TXDATA (write-only, reads 0): a store while idle latches `wdata[7:0]` and starts a frame; a store while busy is dropped silently.
- Offset 0x4 RXDATA (read): `{24'b0, rx_byte}`. A load hit clears `rx_valid` at the next edge.
- Offset 0x8 STATUS: bit0 `tx_busy`, bit1 `rx_valid`, bit2 `rx_overrun`, bit3 `frame_err`, others 0. Writing 1 to bit2 or bit3 clears that bit (W1C).
- Offset 0xC: reserved; reads 0, writes ignored.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - Each state holds for CLKS_PER_BIT cycles.
  - DATA shifts 8 bits LSB-first under a 3-bit index.
- RX path: a 2-flop synchroniser feeds the FSM IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge enters START.
  - START: at half-bit (CLKS_PER_BIT/2, truncated), the line is re-sampled. Low proceeds to DATA; high is a glitch and returns to IDLE.
  - DATA: samples 8 bits at mid-bit, LSB-first.
  - STOP: the stop bit is sampled at mid-bit.
    - Stop high: load `rx_byte` and set `rx_valid`.
    - Stop low: set `frame_err`, discard the byte, leave `rx_valid` unchanged.
- Overrun: a completed byte while `rx_valid`=1 and no pop in the same cycle sets `rx_overrun` and keeps the old byte.
- Pop and completion in the same cycle: the new byte is loaded, `rx_valid` stays 1, no overrun.
- Baud counter is shared per FSM (one TX, one RX); it wraps at CLKS_PER_BIT-1 and resets to 0 on every state change.

## Timing
- Reset values:
  - `tx` = 1.
  - All FSMs IDLE, counters 0.
  - `tx_busy`, `rx_valid`, `rx_overrun`, `frame_err` = 0; `rx_byte` = 0.
  - `rdata` = 0 for every address.
- Reset asserted mid-frame aborts immediately: `tx` goes high asynchronously, and any partial RX byte is lost.
- TX store accepted at edge N:
  - `tx` low from edge N+1.
  - `tx_busy` = 1 from edge N+1 through the end of the stop bit, 10×CLKS_PER_BIT cycles in total.
  - A new store is accepted in the first cycle `tx_busy` reads 0.
- `rdata` is combinational in the same cycle as `addr`; status changes are visible one cycle after the causing edge.
- RX latency: `rx_valid` rises 2 cycles (synchroniser) plus mid-stop-bit after the start edge, i.e. about 9.5×CLKS_PER_BIT+2 cycles.

## Configuration
- `UART_RX_EN` defined: the receiver, synchroniser and RX status bits are present.
- `UART_RX_EN` undefined:
  - `rx` is unused.
  - RXDATA reads 0; STATUS bits1–3 read 0; their W1C writes are ignored.
  - The transmitter is unchanged.

## Structure
- Package `uart_mmio_pkg`:
  - register offsets (`OFF_TXDATA`, `OFF_RXDATA`, `OFF_STATUS`);
  - STATUS bit indices;
  - the shared 2-bit state enum `uart_state_t` (IDLE/START/DATA/STOP).
- One sub-module `uart_rx`: synchroniser plus RX FSM, outputs `byte` and a one-cycle `done`/`ferr` pulse, instantiated under `UART_RX_EN`. Register file and TX FSM stay in `uart_mmio`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and BASE_ADDR=0x1000.
- Reset then load 0x1008 → `rdata`=0, `tx`=1.
- Store 0xA5 to 0x1000 → `tx` sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1; STATUS bit0 = 1 for 40 cycles, then 0.
- Store 0x3C while busy sending 0xA5 → ignored; only the 0xA5 frame appears.
- Drive RX frame 0x5A → STATUS = 0x2, RXDATA = 0x5A; after the load, STATUS = 0x0.
- Drive two frames 0x11 and 0x22 without reading → RXDATA = 0x11, STATUS = 0x6; store 0x4 to 0x1008 → STATUS = 0x2.
- Drive frame 0x33 with stop bit low → STATUS bit3 = 1, `rx_valid` = 0. A 1-cycle low glitch on `rx` → no state change.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions and the state encoding used by both the TX and RX sequencers.
package uart_mmio_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_RXDATA = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;

   localparam int ST_TX_BUSY    = 0;
   localparam int ST_RX_VALID   = 1;
   localparam int ST_RX_OVERRUN = 2;
   localparam int ST_FRAME_ERR  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_mmio_rx.sv
// Receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Emits the received byte with a one-cycle done pulse, or a one-cycle ferr pulse.
module uart_rx
   import uart_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       done,
   output logic       ferr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1, sync2, prev;
   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         data  <= '0;
         done  <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
         prev  <= sync2;
         done  <= 1'b0;
         ferr  <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (prev && !sync2) state <= START;
            end
            // Leaving START at mid start-bit aligns every later full-bit wait to mid-bit.
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= sync2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shift <= {sync2, shift[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (sync2) begin
                     data <= shift;
                     done <= 1'b1;
                  end else begin
                     ferr <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio.sv
// Polled UART on the core data port: TXDATA/RXDATA/STATUS register window and
// TX sequencer. Define UART_RX_EN to include the receiver and its status bits.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        memwrite,
   input  logic        resultsrc,
   output logic [31:0] rdata,
   output logic        tx,
   input  logic        rx
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic       hit, wr_tx, tx_busy;
   logic [3:0] off;
   logic [7:0] rx_byte;
   logic       rx_valid, rx_overrun, frame_err;
   logic       unused_bits;

   assign hit   = (addr[31:4] == BASE_ADDR[31:4]);
   assign off   = {addr[3:2], 2'b00};
   assign wr_tx = hit && memwrite && (off == OFF_TXDATA);

   uart_state_t   tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_idx;
   logic [7:0]    tx_shift;

   assign tx_busy = (tx_state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            IDLE: begin
               tx_cnt <= '0;
               tx_idx <= '0;
               tx     <= 1'b1;
               if (wr_tx) begin
                  tx_shift <= wdata[7:0];
                  tx       <= 1'b0;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == LAST) begin
                  tx_cnt   <= '0;
                  tx       <= tx_shift[0];
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            // tx_shift[0] is always the bit currently on the line.
            DATA: begin
               if (tx_cnt == LAST) begin
                  tx_cnt <= '0;
                  tx_idx <= tx_idx + 3'd1;
                  if (tx_idx == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     tx       <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tx_cnt == LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_EN
   logic       pop, wr_status, rx_done, rx_ferr;
   logic [7:0] rx_data;

   assign pop       = hit && resultsrc && (off == OFF_RXDATA);
   assign wr_status = hit && memwrite && (off == OFF_STATUS);

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .data  (rx_data),
      .done  (rx_done),
      .ferr  (rx_ferr)
   );

   // A pop in the completion cycle frees the holder, so the new byte lands without overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_byte    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (rx_done && (!rx_valid || pop)) begin
            rx_byte  <= rx_data;
            rx_valid <= 1'b1;
         end else if (pop) begin
            rx_valid <= 1'b0;
         end
         if (rx_done && rx_valid && !pop)
            rx_overrun <= 1'b1;
         else if (wr_status && wdata[ST_RX_OVERRUN])
            rx_overrun <= 1'b0;
         if (rx_ferr)
            frame_err <= 1'b1;
         else if (wr_status && wdata[ST_FRAME_ERR])
            frame_err <= 1'b0;
      end
   end

   assign unused_bits = ^{addr[1:0], wdata[31:8]};
`else
   assign rx_byte     = '0;
   assign rx_valid    = 1'b0;
   assign rx_overrun  = 1'b0;
   assign frame_err   = 1'b0;
   assign unused_bits = ^{addr[1:0], wdata[31:8], resultsrc, rx};
`endif

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (off)
            OFF_RXDATA: rdata = {24'b0, rx_byte};
            OFF_STATUS: begin
               rdata[ST_TX_BUSY]    = tx_busy;
               rdata[ST_RX_VALID]   = rx_valid;
               rdata[ST_RX_OVERRUN] = rx_overrun;
               rdata[ST_FRAME_ERR]  = frame_err;
            end
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio (CLKS_PER_BIT=4, BASE=0x1000); randomized bytes
// checked against a register-level model of TX frames and RX holding-register rules.
module tb_uart_mmio;

   localparam int          CPB  = 4;
   localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        memwrite = 1'b0;
   logic        resultsrc = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] rdata;
   logic        tx;

   int vectors = 0;
   int miscompares = 0;

   // Reference model of the receive-side software-visible state
   bit         m_valid, m_ovr, m_ferr;
   logic [7:0] m_byte;

   uart_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .memwrite  (memwrite),
      .resultsrc (resultsrc),
      .rdata     (rdata),
      .tx        (tx),
      .rx        (rx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   function automatic logic [31:0] exp_status(input bit busy);
      logic [31:0] s;
      s = 32'b0;
      s[0] = busy;
      if (RX_EN) begin
         s[1] = m_valid;
         s[2] = m_ovr;
         s[3] = m_ferr;
      end
      return s;
   endfunction

   function automatic logic [31:0] exp_rxdata();
      return RX_EN ? {24'b0, m_byte} : 32'b0;
   endfunction

   task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
      addr = a;
      resultsrc = 1'b1;
      #1 v = rdata;
      @(negedge clk);
      resultsrc = 1'b0;
      addr = '0;
      if (a == BASE + 32'h4) m_valid = 1'b0;
   endtask

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      memwrite = 1'b1;
      @(negedge clk);
      memwrite = 1'b0;
      addr = '0;
      wdata = '0;
      if (a == BASE + 32'h8) begin
         if (d[2]) m_ovr = 1'b0;
         if (d[3]) m_ferr = 1'b0;
      end
   endtask

   // Called at the first negedge after the store was accepted; samples each bit mid-way.
   task automatic watch_tx(input logic [7:0] b, input bit inject, input bit chain,
                           input logic [7:0] nb);
      int first_zero;
      int late_low;
      logic [9:0] frame;
      logic [9:0] seen;
      first_zero = -1;
      late_low = 0;
      frame = {1'b1, b, 1'b0};
      seen = '1;
      for (int t = 0; t < 50; t++) begin
         if (inject && t == 10) begin
            addr = BASE; wdata = {24'b0, nb}; memwrite = 1'b1; #1;
         end else if (inject && t == 14) begin
            addr = BASE + 32'h1008; resultsrc = 1'b1; #1;
            vectors++;
            if (rdata !== 32'b0) begin
               $display("FAIL off_window_read: got %h expected %h", rdata, 32'b0); miscompares++;
            end
         end else if (inject && t == 15) begin
            addr = BASE + 32'hC; resultsrc = 1'b1; #1;
            vectors++;
            if (rdata !== 32'b0) begin
               $display("FAIL reserved_read: got %h expected %h", rdata, 32'b0); miscompares++;
            end
         end else if (inject && t == 16) begin
            addr = BASE + 32'hA; resultsrc = 1'b1; #1;
            vectors++;
            if (rdata !== exp_status(1'b1)) begin
               $display("FAIL status_low_bits_ignored: got %h expected %h", rdata, exp_status(1'b1));
               miscompares++;
            end
         end else if (inject && t == 17) begin
            addr = BASE; resultsrc = 1'b1; #1;
            vectors++;
            if (rdata !== 32'b0) begin
               $display("FAIL txdata_reads_zero: got %h expected %h", rdata, 32'b0); miscompares++;
            end
         end else begin
            addr = BASE + 32'h8; resultsrc = 1'b1; #1;
            if (first_zero < 0 && rdata[0] == 1'b0) first_zero = t;
         end
         if (t % 4 == 2 && t / 4 < 10) seen[t/4] = tx;
         if (t >= 40 && tx == 1'b0) late_low++;
         if (chain && first_zero == t) begin
            resultsrc = 1'b0; addr = BASE; wdata = {24'b0, nb}; memwrite = 1'b1;
            @(negedge clk);
            memwrite = 1'b0;
            break;
         end
         @(negedge clk);
         memwrite = 1'b0;
         resultsrc = 1'b0;
      end
      addr = '0; wdata = '0; resultsrc = 1'b0;
      $display("tx frame byte=%h bits=%b busy_cycles=%0d", b, seen, first_zero);
      vectors++;
      if (seen !== frame) begin
         $display("FAIL tx_frame_%h: got %b expected %b", b, seen, frame); miscompares++;
      end
      vectors++;
      if (first_zero != 10 * CPB) begin
         $display("FAIL tx_busy_len_%h: got %0d expected %0d", b, first_zero, 10 * CPB); miscompares++;
      end
      if (!chain) begin
         vectors++;
         if (late_low != 0) begin
            $display("FAIL tx_idle_after_%h: got %0d low cycles expected 0", b, late_low); miscompares++;
         end
      end
   endtask

   task automatic drive_rx(input logic [7:0] b, input bit stop_ok);
      logic [9:0] f;
      f = {stop_ok, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rx = f[k];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (6) @(negedge clk);
      if (!stop_ok) m_ferr = 1'b1;
      else if (m_valid) m_ovr = 1'b1;
      else begin m_byte = b; m_valid = 1'b1; end
      $display("rx frame byte=%h stop=%0d", b, stop_ok);
   endtask

   task automatic check_status(input string name);
      logic [31:0] v, e;
      e = exp_status(1'b0);
      read_reg(BASE + 32'h8, v);
      vectors++;
      if (v !== e) begin
         $display("FAIL %s: got %h expected %h", name, v, e); miscompares++;
      end
   endtask

   task automatic check_rxdata(input string name);
      logic [31:0] v, e;
      e = exp_rxdata();
      read_reg(BASE + 32'h4, v);
      vectors++;
      if (v !== e) begin
         $display("FAIL %s: got %h expected %h", name, v, e); miscompares++;
      end
   endtask

   task automatic test_reset();
      m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (tx !== 1'b1) begin
         $display("FAIL reset_tx: got %b expected 1", tx); miscompares++;
      end
      for (int i = 0; i < 4; i++) begin
         addr = BASE + 32'(i * 4); resultsrc = 1'b1; #1;
         vectors++;
         if (rdata !== 32'b0) begin
            $display("FAIL reset_rdata_off%0d: got %h expected %h", i * 4, rdata, 32'b0); miscompares++;
         end
      end
      resultsrc = 1'b0; addr = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_status("post_reset_status");
      vectors++;
      if (tx !== 1'b1) begin
         $display("FAIL post_reset_tx: got %b expected 1", tx); miscompares++;
      end
      $display("reset checked");
   endtask

   task automatic test_tx_basic();
      write_reg(BASE, 32'hA5);
      watch_tx(8'hA5, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_busy_drop();
      write_reg(BASE, 32'hA5);
      watch_tx(8'hA5, 1'b1, 1'b0, 8'h3C);
   endtask

   task automatic test_tx_random();
      logic [7:0] b;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         write_reg(BASE, {24'b0, b});
         watch_tx(b, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      write_reg(BASE, {24'b0, a});
      watch_tx(a, 1'b0, 1'b1, b);
      watch_tx(b, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_rx_basic();
      drive_rx(8'h5A, 1'b1);
      check_status("rx_basic_status");
      check_rxdata("rx_basic_data");
      check_status("rx_basic_status_after_pop");
   endtask

   task automatic test_rx_overrun();
      drive_rx(8'h11, 1'b1);
      drive_rx(8'h22, 1'b1);
      check_status("overrun_status");
      write_reg(BASE + 32'h8, 32'h4);
      check_status("overrun_cleared_status");
      check_rxdata("overrun_keeps_first");
      check_status("overrun_after_pop");
   endtask

   task automatic test_rx_frame_err();
      drive_rx(8'h33, 1'b0);
      check_status("frame_err_status");
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      $display("rx glitch applied");
      check_status("glitch_status");
      check_rxdata("glitch_rxdata");
      write_reg(BASE + 32'h8, 32'h8);
      check_status("frame_err_cleared");
   endtask

   task automatic test_rx_random();
      logic [7:0] b;
      bit ok;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         ok = ($urandom_range(3) != 0);
         drive_rx(b, ok);
         check_status("rx_random_status");
         if ($urandom_range(1) == 1) check_rxdata("rx_random_data");
      end
      write_reg(BASE + 32'h8, 32'hC);
      check_rxdata("rx_random_final_data");
      check_status("rx_random_final_status");
   endtask

   task automatic test_reset_midframe();
      write_reg(BASE, 32'h00);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (tx !== 1'b1) begin
         $display("FAIL async_reset_tx: got %b expected 1", tx); miscompares++;
      end
      addr = BASE + 32'h8; resultsrc = 1'b1; #1;
      vectors++;
      if (rdata !== 32'b0) begin
         $display("FAIL async_reset_status: got %h expected %h", rdata, 32'b0); miscompares++;
      end
      resultsrc = 1'b0; addr = '0;
      m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = '0;
      @(negedge clk);
      rx = 1'b1;
      reset = 1'b1;
      repeat (50) @(negedge clk);
      check_status("after_midframe_reset_status");
      check_rxdata("after_midframe_reset_rxdata");
      vectors++;
      if (tx !== 1'b1) begin
         $display("FAIL after_midframe_reset_tx: got %b expected 1", tx); miscompares++;
      end
      $display("mid-frame reset checked");
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_busy_drop();
      test_tx_random();
      test_back_to_back();
      test_rx_basic();
      test_rx_overrun();
      test_rx_frame_err();
      test_rx_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
